// File: rtl/control_sequencer_if.sv
// Control-sequencer / datapath bundle: IR and flags in, control vector and immediate out.
interface control_sequencer_if;
   logic [31:0] instruction_reg_out;
   logic [4:0]  alu_status;
   logic [36:0] control_word;
   logic [63:0] constant;
   logic [2:0]  state;
   logic        halted;
   logic        illegal;

   modport master (
      input  instruction_reg_out, alu_status,
      output control_word, constant, state, halted, illegal
   );

   modport slave (
      output instruction_reg_out, alu_status,
      input  control_word, constant, state, halted, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer driving a datapath/memory control word.
// Optional macro CTRL_ILLEGAL_TRAP_EN: class-111 instructions trap to HALT with a sticky illegal flag.
module control_sequencer #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic               clock,
   input  logic               reset,
   control_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      C_ALU_REG = 3'd0,
      C_ALU_IMM = 3'd1,
      C_LOAD    = 3'd2,
      C_STORE   = 3'd3,
      C_B       = 3'd4,
      C_BZ      = 3'd5,
      C_HALT    = 3'd6,
      C_ILLEGAL = 3'd7
   } class_e;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_e      state_q;
   logic [3:0]  wait_q;
   class_e      ir_class;
   logic        last_wait;
   logic [4:0]  ir_fs, ir_rm, ir_rn, ir_rd;
   logic [63:0] imm_ext, br_off, ir_const;
   logic        unused_flags;

   assign ir_class  = class_e'(bus.instruction_reg_out[31:29]);
   assign ir_fs     = bus.instruction_reg_out[28:24];
   assign ir_rm     = bus.instruction_reg_out[14:10];
   assign ir_rn     = bus.instruction_reg_out[9:5];
   assign ir_rd     = bus.instruction_reg_out[4:0];
   assign imm_ext   = {{55{bus.instruction_reg_out[23]}}, bus.instruction_reg_out[23:15]};
   assign br_off    = {{38{bus.instruction_reg_out[28]}}, bus.instruction_reg_out[28:5], 2'b00};
   assign last_wait = (wait_q == WAIT_LAST);
   assign unused_flags = &{1'b0, bus.alu_status[4:1]};

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_RST;
         wait_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_RST: begin
               state_q <= ST_FETCH;
               wait_q  <= '0;
            end
            // FETCH and MEM share the wait counter; it clears whenever either is left
            ST_FETCH, ST_MEM: begin
               if (last_wait) begin
                  state_q <= (state_q == ST_FETCH) ? ST_DECODE : ST_FETCH;
                  wait_q  <= '0;
               end else begin
                  wait_q  <= wait_q + 4'd1;
               end
            end
            ST_DECODE: begin
               wait_q <= '0;
               case (ir_class)
                  C_HALT:    state_q <= ST_HALT;
                  C_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     illegal_q <= 1'b1;
                     state_q   <= ST_HALT;
`else
                     state_q   <= ST_FETCH;
`endif
                  end
                  default:   state_q <= ST_EXEC;
               endcase
            end
            ST_EXEC: begin
               wait_q  <= '0;
               state_q <= (ir_class == C_LOAD || ir_class == C_STORE) ? ST_MEM : ST_FETCH;
            end
            ST_HALT: begin
               wait_q  <= '0;
               state_q <= ST_HALT;
            end
            default: begin
               wait_q  <= '0;
               state_q <= ST_RST;
            end
         endcase
      end
   end

   logic [4:0] da, sa, sb, fs;
   logic [1:0] pc_sel, size;
   logic       reg_write, b_sel, mem_read, mem_write, ir_load, addr_sel, data_sel, status_load;

   always_comb begin
      da          = '0;
      sa          = '0;
      sb          = '0;
      fs          = '0;
      pc_sel      = 2'b00;
      size        = 2'b00;
      reg_write   = 1'b0;
      b_sel       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_load     = 1'b0;
      addr_sel    = 1'b0;
      data_sel    = 1'b0;
      status_load = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            mem_read = 1'b1;
            size     = 2'b11;
            if (last_wait) begin
               ir_load = 1'b1;
               pc_sel  = 2'b01;
            end
         end
         ST_EXEC: begin
            case (ir_class)
               C_ALU_REG, C_ALU_IMM: begin
                  da          = ir_rd;
                  sa          = ir_rn;
                  sb          = ir_rm;
                  fs          = ir_fs;
                  reg_write   = 1'b1;
                  status_load = 1'b1;
                  b_sel       = (ir_class == C_ALU_IMM);
               end
               C_B:     pc_sel = 2'b10;
               C_BZ:    pc_sel = bus.alu_status[0] ? 2'b10 : 2'b00;
               default: ;
            endcase
         end
         // Address is Rn + sext(imm9) through the ALU add; store data rides on SB
         ST_MEM: begin
            sa       = ir_rn;
            b_sel    = 1'b1;
            addr_sel = 1'b1;
            size     = 2'b11;
            if (ir_class == C_STORE) begin
               sb        = ir_rd;
               mem_write = 1'b1;
            end else begin
               da        = ir_rd;
               mem_read  = 1'b1;
               data_sel  = 1'b1;
               reg_write = last_wait;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ir_class)
         C_ALU_IMM, C_LOAD, C_STORE: ir_const = imm_ext;
         C_B, C_BZ:                  ir_const = br_off;
         default:                    ir_const = '0;
      endcase
   end

   assign bus.control_word = {5'b0, status_load, data_sel, addr_sel, ir_load, mem_write,
                              mem_read, size, pc_sel, b_sel, reg_write, fs, sb, sa, da};
   assign bus.constant     = (state_q == ST_DECODE || state_q == ST_EXEC || state_q == ST_MEM)
                             ? ir_const : '0;
   assign bus.state        = state_q;
   assign bus.halted       = (state_q == ST_HALT);
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign bus.illegal      = illegal_q;
`else
   assign bus.illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer; honours CTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_control_sequencer;

   localparam int unsigned W = 1;

   typedef struct {
      logic [2:0]  st;
      logic [36:0] cw;
      logic [63:0] k;
      logic        h;
      logic        il;
   } rec_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   control_sequencer_if bus ();

   control_sequencer #(.MEM_WAIT(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   rec_t seq[$];
   rec_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic m_illegal = 1'b0;

   function automatic rec_t mk(int st, logic [36:0] cw, logic [63:0] k, logic h, logic il);
      rec_t r;
      r.st = 3'(st); r.cw = cw; r.k = k; r.h = h; r.il = il;
      return r;
   endfunction

   // Appends the expected per-cycle outputs of one instruction; returns 1 if it halts.
   function automatic bit model_instr(logic [31:0] ir, logic [4:0] stat);
      logic [2:0]  cls = ir[31:29];
      logic [63:0] k;
      logic [36:0] rd = 37'(ir[4:0]);
      logic [36:0] rn = 37'(ir[9:5]);
      logic [36:0] rm = 37'(ir[14:10]);
      logic [36:0] fs = 37'(ir[28:24]);
      logic [8:0]  imm = ir[23:15];
      logic [23:0] off = ir[28:5];
      case (cls)
         3'd1, 3'd2, 3'd3: k = 64'(longint'($signed(imm)));
         3'd4, 3'd5:       k = 64'(longint'($signed(off)) * 4);
         default:          k = 64'd0;
      endcase
      for (int unsigned w = 0; w <= W; w++)
         seq.push_back(mk(1, (37'd1 << 26) | (37'd3 << 24) |
                          ((w == W) ? ((37'd1 << 28) | (37'd1 << 22)) : 37'd0), 64'd0, 1'b0, m_illegal));
      seq.push_back(mk(2, 37'd0, k, 1'b0, m_illegal));
      case (cls)
         3'd0, 3'd1:
            seq.push_back(mk(3, rd | (rn << 5) | (rm << 10) | (fs << 15) | (37'd1 << 20) |
                             ((cls == 3'd1) ? (37'd1 << 21) : 37'd0) | (37'd1 << 31), k, 1'b0, m_illegal));
         3'd2, 3'd3: begin
            seq.push_back(mk(3, 37'd0, k, 1'b0, m_illegal));
            for (int unsigned w = 0; w <= W; w++) begin
               if (cls == 3'd2)
                  seq.push_back(mk(4, rd | (rn << 5) | (37'd1 << 21) | (37'd3 << 24) | (37'd1 << 26) |
                                   (37'd1 << 29) | (37'd1 << 30) | ((w == W) ? (37'd1 << 20) : 37'd0),
                                   k, 1'b0, m_illegal));
               else
                  seq.push_back(mk(4, (rn << 5) | (rd << 10) | (37'd1 << 21) | (37'd3 << 24) |
                                   (37'd1 << 27) | (37'd1 << 29), k, 1'b0, m_illegal));
            end
         end
         3'd4: seq.push_back(mk(3, 37'd2 << 22, k, 1'b0, m_illegal));
         3'd5: seq.push_back(mk(3, stat[0] ? (37'd2 << 22) : 37'd0, k, 1'b0, m_illegal));
         3'd6: begin
            for (int i = 0; i < 20; i++) seq.push_back(mk(5, 37'd0, 64'd0, 1'b1, m_illegal));
            return 1'b1;
         end
         default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            m_illegal = 1'b1;
            for (int i = 0; i < 20; i++) seq.push_back(mk(5, 37'd0, 64'd0, 1'b1, m_illegal));
            return 1'b1;
`endif
         end
      endcase
      return 1'b0;
   endfunction

   task automatic step(input rec_t e);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic run_seq(input int abort_at);
      int n;
      for (int i = 0; i < seq.size(); i++) begin
         reset = (i == abort_at);
         step(seq[i]);
         if (i == abort_at) begin
            m_illegal = 1'b0;
            n = $urandom_range(0, 2);
            repeat (n) step(mk(0, 37'd0, 64'd0, 1'b0, 1'b0));
            reset = 1'b0;
            step(mk(0, 37'd0, 64'd0, 1'b0, 1'b0));
            break;
         end
      end
      seq.delete();
   endtask

   // abort: >=0 reset at that cycle index, -1 random choice, -2 never
   task automatic issue(input logic [31:0] ir, input logic [4:0] stat, input int abort);
      bit halts;
      int at;
      bus.instruction_reg_out = ir;
      bus.alu_status          = stat;
      halts = model_instr(ir, stat);
      if (abort >= 0)       at = abort;
      else if (halts)       at = seq.size() - 1;
      else if (abort == -1 && $urandom_range(0, 7) == 0) at = $urandom_range(0, seq.size() - 1);
      else                  at = -1;
      run_seq(at);
   endtask

   always @(negedge clock) begin
      rec_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (bus.state !== e.st || bus.control_word !== e.cw || bus.constant !== e.k ||
             bus.halted !== e.h || bus.illegal !== e.il || (bus.control_word[26] & bus.control_word[27]) !== 1'b0) begin
            miscompares++;
            $display("FAIL cycle%0d: got state=%0d cw=%h k=%h halted=%b illegal=%b, want state=%0d cw=%h k=%h halted=%b illegal=%b",
                     vectors, bus.state, bus.control_word, bus.constant, bus.halted, bus.illegal,
                     e.st, e.cw, e.k, e.h, e.il);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] cls;
      int r;
      reset = 1'b1;
      bus.instruction_reg_out = '0;
      bus.alu_status = '0;
      @(posedge clock);
      #1;
      step(mk(0, 37'd0, 64'd0, 1'b0, 1'b0));
      reset = 1'b0;
      step(mk(0, 37'd0, 64'd0, 1'b0, 1'b0));

      issue({3'b000, 5'd6, 9'd0, 5'd2, 5'd1, 5'd3}, 5'd0, -2);
      issue({3'b010, 5'd0, 9'h1F8, 5'd0, 5'd5, 5'd4}, 5'd0, -2);
      issue({3'b101, 24'd3, 5'd0}, 5'b00001, -2);
      issue({3'b101, 24'd3, 5'd0}, 5'b00000, -2);
      issue({3'b011, 5'd0, 9'h010, 5'd0, 5'd2, 5'd7}, 5'd0, int'(W) + 3);
      issue({3'b001, 5'd3, 9'h1FF, 5'd9, 5'd8, 5'd31}, 5'd0, -2);
      issue({3'b100, 24'hFFFFFF, 5'd0}, 5'd0, -2);
      issue({3'b111, 29'd0}, 5'd0, -2);
      issue({3'b110, 29'd0}, 5'd0, -2);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         cls = (r < 3) ? 3'd6 : (r < 6) ? 3'd7 : 3'($urandom_range(0, 5));
         issue({cls, 29'($urandom)}, 5'($urandom), -1);
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
